// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a two-half-adder full-add step.
// Define SERIAL_ADDER_OVERFLOW_EN to add a signed-overflow output held alongside sum.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-2:0] part_q, part_d;
  logic [WIDTH-1:0] part_ext;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ha1_s, ha1_c, bit_s, ha2_c, carry_nx;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  half_adder u_ha1 (.a_i(a_q[0]), .b_i(b_q[0]),   .sum_o(ha1_s), .carry_o(ha1_c));
  half_adder u_ha2 (.a_i(ha1_s),  .b_i(carry_q),  .sum_o(bit_s), .carry_o(ha2_c));

  assign carry_nx = ha1_c | ha2_c;
  // Partial result collects bits 0..WIDTH-2; the final step appends the MSB on top.
  assign part_ext = {bit_s, part_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_d     = a;
          b_d     = b;
          part_d  = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        part_d  = part_ext[WIDTH-1:1];
        carry_d = carry_nx;
        cnt_d   = cnt_q + CW'(1);
        // Visible results update only on the last bit step so they hold through the next add.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          sum_d   = part_ext;
          cout_d  = carry_nx;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = carry_q ^ carry_nx;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Overflow checks are compiled in when SERIAL_ADDER_OVERFLOW_EN is defined.

module tb_serial_adder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns the number of falling edges until done is seen, or -1 on timeout.
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic quiet(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  // Called at a falling edge: presents operands, then checks latency and result.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] es, input logic ec, input string tag);
    int lat;
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(20, lat);
    check({tag, ".lat"}, 32'(lat), 32'd8);
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(carry_out), 32'(ec));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, ".done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;

    #1 rst = 1'b1;
    #2;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("rst.ovf", 32'(overflow), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // First start on the very first edge after reset release.
    do_add(8'h0F, 8'h01, 8'h10, 1'b0, "add_0f_01");

    @(negedge clk);
    do_add(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
    @(negedge clk);
    do_add(8'h5A, 8'hA5, 8'hFF, 1'b0, "add_5a_a5");
    @(negedge clk);
    do_add(8'hC8, 8'h64, 8'h2C, 1'b1, "add_c8_64");

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, lat);
    check("busy_start.lat", 32'(lat), 32'd5);
    check("busy_start.sum", 32'(sum), 32'h46);
    check("busy_start.cout", 32'(carry_out), 32'd0);
    quiet(12, pulses);
    check("busy_start.extra_done", 32'(pulses), 32'd0);

    // Asynchronous reset mid-shift.
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.cout", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet(12, pulses);
    check("abort.no_done", 32'(pulses), 32'd0);
    @(negedge clk);
    do_add(8'h01, 8'h02, 8'h03, 1'b0, "after_abort");

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    wait_done(20, lat);
    check("b2b.lat1", 32'(lat), 32'd8);
    check("b2b.sum1", 32'(sum), 32'h00);
    check("b2b.cout1", 32'(carry_out), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b.done_drop", 32'(done), 32'd0);
    check("b2b.busy2", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("b2b.hold_sum", 32'(sum), 32'h00);
    check("b2b.hold_cout", 32'(carry_out), 32'd1);
    wait_done(20, lat);
    check("b2b.gap", 32'(lat + 4), 32'd9);
    check("b2b.sum2", 32'(sum), 32'h07);
    check("b2b.cout2", 32'(carry_out), 32'd0);

`ifdef SERIAL_ADDER_OVERFLOW_EN
    @(negedge clk);
    do_add(8'h7F, 8'h01, 8'h80, 1'b0, "ovf_7f_01");
    check("ovf_7f_01.ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    do_add(8'hFF, 8'h01, 8'h00, 1'b1, "ovf_ff_01");
    check("ovf_ff_01.ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    do_add(8'h80, 8'h80, 8'h00, 1'b1, "ovf_80_80");
    check("ovf_80_80.ovf", 32'(overflow), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
